router_stat_trigger: RTL and testbench

Upstream companion of the per-router link-utilization profilers. It owns the free-running global cycle counter and generates the single-cycle `print_stat_v` / `print_stat_tag` pulse that every router profiler samples to dump its counters. Pulses come from two sources: host print-stat requests and an optional periodic timer. It sits once per testbench and is broadcast to all profiler instances.

---
 rtl/router_stat_pkg.sv | 14 +
 rtl/router_stat_period_timer.sv | 48 ++++
 rtl/router_stat_trigger.sv | 105 ++++++++++
 tb/tb_router_stat_trigger.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/router_stat_pkg.sv
// Shared types for the router statistics trigger and the profilers
// that decode its print-stat tags.
package router_stat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } stat_state_e;

  // MSB of a print tag: 1 marks a periodic dump, 0 a host request
  localparam logic periodic_tag_mark = 1'b1;

endpackage

// File: rtl/router_stat_period_timer.sv
// Periodic dump timer: period counter, pending request, overrun flag
// and the periodic sequence number.
module router_stat_period_timer
  import router_stat_pkg::*;
#(
  parameter int unsigned period_p    = 250,
  parameter int unsigned enable_p    = 0,
  parameter int unsigned seq_width_p = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  output logic                   pending,
  output logic [seq_width_p-1:0] seq,
  output logic                   overrun
);

  localparam int unsigned cnt_w = $clog2(period_p);

  logic [cnt_w-1:0] cnt;
  logic             wrap;

  assign wrap = (enable_p != 0) && en
             && (cnt == cnt_w'(period_p - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
      seq     <= '0;
      overrun <= 1'b0;
    end else begin
      if (en && (enable_p != 0))
        cnt <= wrap ? '0 : cnt + 1'b1;
      // a new tick wins over the clear of the one being emitted
      if (wrap)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
      if (wrap && pending)
        overrun <= 1'b1;
      if (clr)
        seq <= seq + 1'b1;
    end
  end

endmodule

// File: rtl/router_stat_trigger.sv
// Global cycle counter and single-cycle print-stat pulse generator
// fed by host requests and an optional periodic timer.
module router_stat_trigger
  import router_stat_pkg::*;
#(
  parameter int unsigned period_p          = 250,
  parameter int unsigned enable_periodic_p = 0,
  parameter int unsigned gap_p             = 2,
  parameter int unsigned tag_width_p       = 32,
  parameter int unsigned ctr_width_p       = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   en_i,
  input  logic                   host_v_i,
  input  logic [tag_width_p-1:0] host_tag_i,
  output logic                   host_ready_o,
  output logic                   print_stat_v_o,
  output logic [tag_width_p-1:0] print_stat_tag_o,
  output logic [ctr_width_p-1:0] global_ctr_o,
  output logic                   periodic_overrun_o
);

  localparam int unsigned gap_w = $clog2(gap_p + 1);

  stat_state_e            state, state_n;
  logic [ctr_width_p-1:0] global_ctr;
  logic                   host_full;
  logic [tag_width_p-1:0] host_tag;
  logic                   src_host;
  logic [gap_w-1:0]       gap_ctr;
  logic [tag_width_p-1:0] print_tag;
  logic                   handshake;
  logic                   clr_host;
  logic                   clr_periodic;
  logic                   pending;
  logic [tag_width_p-2:0] seq;
  logic                   overrun;

  assign handshake    = host_v_i & ~host_full;
  assign clr_host     = (state == ST_EMIT) & src_host;
  assign clr_periodic = (state == ST_EMIT) & ~src_host;

  router_stat_period_timer #(
    .period_p    (period_p),
    .enable_p    (enable_periodic_p),
    .seq_width_p (tag_width_p - 1)
  ) timer (
    .clk     (clk_i),
    .rst_n   (reset_n_i),
    .en      (en_i),
    .clr     (clr_periodic),
    .pending (pending),
    .seq     (seq),
    .overrun (overrun)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (host_full | pending) state_n = ST_EMIT;
      ST_EMIT: state_n = ST_GAP;
      ST_GAP:  if (gap_ctr == gap_w'(gap_p - 1)) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= ST_IDLE;
      global_ctr <= '0;
      host_full  <= 1'b0;
      host_tag   <= '0;
      src_host   <= 1'b0;
      gap_ctr    <= '0;
      print_tag  <= '0;
    end else begin
      state <= state_n;
      if (en_i)
        global_ctr <= global_ctr + 1'b1;
      if (handshake) begin
        host_full <= 1'b1;
        host_tag  <= host_tag_i;
      end else if (clr_host) begin
        host_full <= 1'b0;
      end
      gap_ctr <= (state == ST_GAP) ? gap_ctr + 1'b1 : '0;
      // source is latched in IDLE; host has priority
      if (state == ST_IDLE)
        src_host <= host_full;
      if (state_n == ST_EMIT)
        print_tag <= host_full ? host_tag
                               : {periodic_tag_mark, seq};
      else
        print_tag <= '0;
    end
  end

  assign host_ready_o       = ~host_full;
  assign print_stat_v_o     = (state == ST_EMIT);
  assign print_stat_tag_o   = print_tag;
  assign global_ctr_o       = global_ctr;
  assign periodic_overrun_o = overrun;

endmodule

// File: tb/tb_router_stat_trigger.sv
// Self-checking bench for router_stat_trigger: directed tables,
// hand sequences and a randomized run against a reference model.
module tb_router_stat_trigger;

  localparam int PER = 8;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic en_a = 0, hv_a = 0;
  logic en_b = 0, hv_b = 0;
  logic en_c = 0, hv_c = 0;
  logic [31:0] tag_a = 0, tag_b = 0, tag_c = 0;
  logic rdy_a, rdy_b, rdy_c, v_a, v_b, v_c;
  logic ovr_a, ovr_b, ovr_c;
  logic [31:0] ptag_a, ptag_b, ptag_c, ctr_a, ctr_b, ctr_c;

  router_stat_trigger #(.period_p(PER), .enable_periodic_p(1),
    .gap_p(GAP)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_a),
    .host_v_i(hv_a), .host_tag_i(tag_a), .host_ready_o(rdy_a),
    .print_stat_v_o(v_a), .print_stat_tag_o(ptag_a),
    .global_ctr_o(ctr_a), .periodic_overrun_o(ovr_a));

  router_stat_trigger #(.period_p(2), .enable_periodic_p(1),
    .gap_p(4)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_b),
    .host_v_i(hv_b), .host_tag_i(tag_b), .host_ready_o(rdy_b),
    .print_stat_v_o(v_b), .print_stat_tag_o(ptag_b),
    .global_ctr_o(ctr_b), .periodic_overrun_o(ovr_b));

  router_stat_trigger #(.period_p(PER), .enable_periodic_p(0),
    .gap_p(GAP)) dut_c (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_c),
    .host_v_i(hv_c), .host_tag_i(tag_c), .host_ready_o(rdy_c),
    .print_stat_v_o(v_c), .print_stat_tag_o(ptag_c),
    .global_ctr_o(ctr_c), .periodic_overrun_o(ovr_c));

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Reference model for dut_a, expressed as time-slot arithmetic
  bit [31:0] m_ctr, m_htag, m_etag;
  int        m_pcnt, m_busy, m_seq;
  bit        m_pend, m_ovr, m_full, m_emit, m_src;

  task automatic model_reset();
    m_ctr = 0; m_htag = 0; m_etag = 0; m_pcnt = 0; m_busy = 0;
    m_seq = 0; m_pend = 0; m_ovr = 0; m_full = 0; m_emit = 0;
    m_src = 0;
  endtask

  task automatic model_check();
    chk("a_v", v_a, m_emit);
    chk("a_tag", ptag_a, m_emit ? m_etag : 32'h0);
    chk("a_ready", rdy_a, !m_full);
    chk("a_ctr", ctr_a, m_ctr);
    chk("a_ovr", ovr_a, m_ovr);
  endtask

  task automatic model_step(input bit en, input bit hv,
                            input bit [31:0] tag);
    bit hs, wrap, start, pend_old;
    bit [31:0] ntag;
    hs       = hv && !m_full;
    wrap     = en && (m_pcnt == PER - 1);
    start    = (m_busy == 0) && (m_full || m_pend);
    ntag     = m_full ? m_htag
                      : (32'h8000_0000 | (32'(m_seq) & 32'h7fff_ffff));
    pend_old = m_pend;
    if (m_emit) begin
      if (m_src) m_full = 0;
      else begin m_pend = 0; m_seq++; end
    end
    if (wrap) begin
      if (pend_old) m_ovr = 1;
      m_pend = 1;
    end
    if (hs) begin m_full = 1; m_htag = tag; end
    m_src  = start ? m_full_before(start) : m_src;
    m_busy = start ? GAP + 1 : (m_busy > 0 ? m_busy - 1 : 0);
    m_emit = start;
    if (start) m_etag = ntag;
    if (en) begin m_ctr++; m_pcnt = (m_pcnt + 1) % PER; end
  endtask

  // source of the emission: host whenever the buffer was full in IDLE
  bit m_full_idle;
  function automatic bit m_full_before(input bit s);
    return s && m_full_idle;
  endfunction

  typedef struct {
    logic        hv;
    logic [31:0] tag;
    logic        ev;
    logic [31:0] etag;
    logic        erdy;
  } vec_t;

  vec_t tbl[41];

  initial begin
    for (int i = 0; i < 41; i++)
      tbl[i] = '{hv: 0, tag: 0, ev: 0, etag: 0, erdy: 1};
    tbl[10] = '{1, 32'h1234, 0, 0, 1};
    tbl[11].erdy = 0;
    tbl[12] = '{0, 0, 1, 32'h1234, 0};
    tbl[20] = '{1, 32'h1, 0, 0, 1};
    tbl[21].erdy = 0;
    tbl[22] = '{0, 0, 1, 32'h1, 0};
    tbl[23] = '{1, 32'h2, 0, 0, 1};
    tbl[24].erdy = 0;
    tbl[25].erdy = 0;
    tbl[26] = '{0, 0, 1, 32'h2, 0};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_v", v_a, 0);
    chk("rst_ctr", ctr_a, 0);
    chk("rst_ready", rdy_a, 1);
    chk("rst_ovr", ovr_b, 0);

    rst_n = 1; en_a = 1; en_b = 1; en_c = 1;
    cyc = 0;
    for (int n = 0; n <= 40; n++) begin
      hv_a  = (n == 23);
      tag_a = 32'h5A;
      hv_c  = tbl[n].hv;
      tag_c = tbl[n].tag;
      en_b  = !(n >= 30 && n <= 34);
      model_check();
      chk("c_v", v_c, tbl[n].ev);
      chk("c_tag", ptag_c, tbl[n].etag);
      chk("c_ready", rdy_c, tbl[n].erdy);
      if (n == 9)  chk("per_tag0", {v_a, ptag_a}, {1'b1, 32'h8000_0000});
      if (n == 17) chk("per_tag1", {v_a, ptag_a}, {1'b1, 32'h8000_0001});
      if (n == 25) chk("sim_host", {v_a, ptag_a}, {1'b1, 32'h5A});
      if (n == 29) chk("sim_per", {v_a, ptag_a, ctr_a},
                       {1'b1, 32'h8000_0002, 32'd29});
      if (n == 0)  chk("b_ovr0", ovr_b, 0);
      if (n == 20 || n == 40) chk("b_ovr1", ovr_b, 1);
      if (n == 35) chk("b_freeze", ctr_b, 30);
      if (n == 36) chk("b_resume", ctr_b, 31);
      m_full_idle = m_full;
      model_step(en_a, hv_a, tag_a);
      tick();
    end

    hv_c = 0;
    for (int n = 0; n < 2000; n++) begin
      en_a  = ($urandom_range(0, 9) < 8);
      hv_a  = ($urandom_range(0, 5) == 0);
      tag_a = $urandom & 32'h7fff_ffff;
      model_check();
      m_full_idle = m_full;
      model_step(en_a, hv_a, tag_a);
      tick();
    end

    en_a = 1; hv_a = 0;
    begin
      int k;
      for (k = 0; k < 50 && !m_emit; k++) begin
        model_check();
        m_full_idle = m_full;
        model_step(en_a, hv_a, tag_a);
        tick();
      end
      chk("wait_pulse", m_emit, 1);
    end
    chk("pre_rst_v", v_a, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_v", v_a, 0);
    chk("rst_mid_tag", ptag_a, 0);
    chk("rst_mid_ctr", ctr_a, 0);
    chk("rst_mid_ready", rdy_a, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc = 0;
    for (int n = 0; n < 20; n++) begin
      model_check();
      if (n == 5) chk("restart_ctr", ctr_a, 5);
      m_full_idle = m_full;
      model_step(en_a, hv_a, tag_a);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
